// File: rtl/gate_delay_pkg.sv
// Shared definitions for the gate/delay blocks: operation encodings,
// default parameter values and the latency clamp helper.
package gate_delay_pkg;

    typedef enum logic [2:0] {
        OP_AND    = 3'd0,
        OP_OR     = 3'd1,
        OP_XOR    = 3'd2,
        OP_NAND   = 3'd3,
        OP_NOR    = 3'd4,
        OP_XNOR   = 3'd5,
        OP_PASS_A = 3'd6,
        OP_NOT_A  = 3'd7
    } gate_op_e;

    localparam int unsigned GDP_WIDTH_DEF       = 8;
    localparam int unsigned GDP_MAX_DELAY_DEF   = 8;
    localparam int unsigned GDP_RESET_DELAY_DEF = 1;

    // Requested latency forced into the legal range 1..max_d.
    function automatic int unsigned clamp_delay(input int unsigned req,
                                                input int unsigned max_d);
        if (req == 0) begin
            return 1;
        end
        if (req > max_d) begin
            return max_d;
        end
        return req;
    endfunction

endpackage

// File: rtl/gate_op_unit.sv
// Purely combinational WIDTH-bit bitwise operation selector.
module gate_op_unit
    import gate_delay_pkg::*;
#(
    parameter int unsigned WIDTH = GDP_WIDTH_DEF
) (
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic [2:0]       op_i,
    output logic [WIDTH-1:0] x_o
);

    // Select the bitwise function; B is ignored for PASS_A and NOT_A.
    always_comb begin
        x_o = '0;
        case (gate_op_e'(op_i))
            OP_AND:    x_o = a_i & b_i;
            OP_OR:     x_o = a_i | b_i;
            OP_XOR:    x_o = a_i ^ b_i;
            OP_NAND:   x_o = ~(a_i & b_i);
            OP_NOR:    x_o = ~(a_i | b_i);
            OP_XNOR:   x_o = ~(a_i ^ b_i);
            OP_PASS_A: x_o = a_i;
            OP_NOT_A:  x_o = ~a_i;
            default:   x_o = '0;
        endcase
    end

endmodule

// File: rtl/gate_delay_pipe.sv
// Gate with runtime-selected bitwise op and programmable latency 1..MAX_DELAY.
// Optional statistics outputs (OUT_COUNT, DROP_FLAG) are enabled by defining
// GATE_DELAY_PIPE_STATS_EN.
module gate_delay_pipe
    import gate_delay_pkg::*;
#(
    parameter  int unsigned WIDTH       = GDP_WIDTH_DEF,
    parameter  int unsigned MAX_DELAY   = GDP_MAX_DELAY_DEF,
    parameter  int unsigned RESET_DELAY = GDP_RESET_DELAY_DEF,
    localparam int unsigned DW          = $clog2(MAX_DELAY + 1)
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic             IN_VALID,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [2:0]       OP,
    input  logic             CFG_WE,
    input  logic [DW-1:0]    CFG_DELAY,
    output logic [WIDTH-1:0] X,
    output logic             OUT_VALID,
    output logic [DW-1:0]    CUR_DELAY
`ifdef GATE_DELAY_PIPE_STATS_EN
    ,
    output logic [15:0]      OUT_COUNT,
    output logic             DROP_FLAG
`endif
);

    // The registered X/OUT_VALID pair is the final stage, so only
    // MAX_DELAY-1 intermediate stages are kept; the output register is
    // loaded from the next-state of the selected tap, which makes latency 1
    // come straight from the op unit.
    localparam int unsigned NST = (MAX_DELAY > 1) ? MAX_DELAY - 1 : 1;

    logic [WIDTH-1:0] res;
    logic [DW-1:0]    cur_q, cur_d;
    logic [NST-1:0]   vld_q, vld_d;
    logic [WIDTH-1:0] dat_q [NST];
    logic [WIDTH-1:0] dat_d [NST];
    logic             ov_q, ov_d;
    logic [WIDTH-1:0] x_q, x_d;
    logic             tap_v;
    logic [WIDTH-1:0] tap_data;
    int unsigned      d_sel;

    gate_op_unit #(.WIDTH(WIDTH)) u_op (
        .a_i  (A),
        .b_i  (B),
        .op_i (OP),
        .x_o  (res)
    );

    // Next latency, flush-aware shift, and tap selection for the output stage.
    always_comb begin
        cur_d = CFG_WE ? DW'(clamp_delay(32'(CFG_DELAY), MAX_DELAY)) : cur_q;
        d_sel = 32'(cur_d);

        vld_d[0] = IN_VALID;
        dat_d[0] = IN_VALID ? res : dat_q[0];
        for (int unsigned k = 1; k < NST; k++) begin
            vld_d[k] = vld_q[k-1] & ~CFG_WE;
            dat_d[k] = dat_q[k-1];
        end

        tap_v    = 1'b0;
        tap_data = res;
        if (d_sel <= 1) begin
            tap_v    = IN_VALID;
            tap_data = res;
        end else begin
            for (int unsigned k = 0; k < NST; k++) begin
                if (d_sel == k + 2) begin
                    tap_v    = vld_q[k] & ~CFG_WE;
                    tap_data = dat_q[k];
                end
            end
        end

        ov_d = tap_v;
        x_d  = tap_v ? tap_data : x_q;
    end

    // Pipeline, output and latency registers.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            cur_q <= DW'(clamp_delay(RESET_DELAY, MAX_DELAY));
            vld_q <= '0;
            for (int unsigned k = 0; k < NST; k++) begin
                dat_q[k] <= '0;
            end
            ov_q  <= 1'b0;
            x_q   <= '0;
        end else begin
            cur_q <= cur_d;
            vld_q <= vld_d;
            for (int unsigned k = 0; k < NST; k++) begin
                dat_q[k] <= dat_d[k];
            end
            ov_q  <= ov_d;
            x_q   <= x_d;
        end
    end

    assign X         = x_q;
    assign OUT_VALID = ov_q;
    assign CUR_DELAY = cur_q;

`ifdef GATE_DELAY_PIPE_STATS_EN
    logic [15:0] cnt_q, cnt_d;
    logic        drop_q, drop_d;
    logic        inflight;

    // A stage is still in flight if its sample has not reached the output
    // tap for the current latency yet.
    always_comb begin
        inflight = 1'b0;
        for (int unsigned k = 0; k < NST; k++) begin
            if (vld_q[k] && (k + 2 <= 32'(cur_q))) begin
                inflight = 1'b1;
            end
        end
        if (CFG_WE) begin
            cnt_d = '0;
        end else if (ov_d && (cnt_q != '1)) begin
            cnt_d = cnt_q + 16'd1;
        end else begin
            cnt_d = cnt_q;
        end
        drop_d = drop_q | (CFG_WE & inflight);
    end

    // Saturating output-pulse counter and sticky drop flag.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            cnt_q  <= '0;
            drop_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            drop_q <= drop_d;
        end
    end

    assign OUT_COUNT = cnt_q;
    assign DROP_FLAG = drop_q;
`endif

endmodule
